reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of register data.
REQ-002 SHALL have parameter ADDR_W, default 3, register address width; bank size NREG = 2**ADDR_W (8).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req0  input  1  requester 0 write request, held until gnt0 seen.
REQ-006 SHALL have port addr0  input  ADDR_W  requester 0 target register.
REQ-007 SHALL have port data0  input  DATA_W  requester 0 write data.
REQ-008 SHALL have ports req1, addr1, data1, identical to requester 0.
REQ-009 SHALL have port hold  input  1  freezes arbitration; no new grants while high.
REQ-010 SHALL have ports gnt0, gnt1  output  1 each  registered one-cycle grant pulses.
REQ-011 SHALL have port wr_en  output  NREG  registered one-hot write enables to the register bank.
REQ-012 SHALL have port wr_data  output  DATA_W  registered data for the bank write.
REQ-013 SHALL have port wr_count  output  8  count of committed writes.

Function
REQ-014 SHALL arbitrate at each rising edge among eligible requesters: reqN high, not granted in the current cycle, and hold low.
REQ-015 SHALL use round-robin priority: on contention, grant the requester not granted most recently (pointer last updates only on a grant).
REQ-016 SHALL assert gntN, wr_en[addrN] and wr_data=dataN during the cycle after the sampling edge; latency 1 cycle, 1-cycle pulse.
REQ-017 SHALL grant at most one requester per cycle; wr_en SHALL be all-zero or exactly one-hot.
REQ-018 SHALL exclude a requester from the edge ending its grant cycle (no double grant while it drops req); sustained single-requester throughput is therefore 1 write per 2 cycles.
REQ-019 SHALL sustain 1 write per cycle when both requesters continuously request (alternating grants).
REQ-020 SHALL, when both requesters target the same address in the same cycle, grant per REQ-015; the loser is granted later, so its data is the final value.
REQ-021 SHALL, when hold is high at an edge, drive gnt0/gnt1/wr_en low for the next cycle; pending requests are served after hold falls, with priority unchanged.
REQ-022 SHALL drive wr_data to 0 in cycles with no grant.
REQ-023 SHALL increment wr_count by 1 per granted write, wrapping 255 -> 0.
REQ-024 SHALL ignore a requester that deasserts req before grant (no write, no count).

Reset
REQ-025 SHALL, when reset is high at an edge, set gnt0=0, gnt1=0, wr_en=0, wr_data=0, wr_count=0, and last=1 (requester 0 wins first contention).
REQ-026 SHALL take reset priority over hold and requests; requests sampled at a reset edge are not granted, and no write occurs in the following cycle.
REQ-027 SHALL treat reset asserted mid-grant as cancelling the next grant only; a grant already driven in the current cycle completes.

Structure
REQ-028 SHALL take DATA_W=16, ADDR_W=3 and NREG from a shared processor definitions package/header used by the register and bank modules.
REQ-029 SHALL instantiate one sub-module, addr_decoder (ADDR_W -> NREG one-hot with enable), to form wr_en.
REQ-030 SHALL drive the existing 16-bit register's write/in ports directly: wr_en[i] -> write of register i, wr_data -> in.

Verification
REQ-031 Reset then req0=1, addr0=5, data0=16'hBEEF for 1 edge -> next cycle gnt0=1, wr_en=8'b0010_0000, wr_data=16'hBEEF, wr_count=1.
REQ-032 req0 and req1 high continuously, addr0=1, addr1=2 after reset -> grants alternate 0,1,0,1; wr_en alternates 8'h02/8'h04; wr_count=4 after 4 cycles.
REQ-033 Both request addr=3, data0=16'h1111, data1=16'h2222, after reset -> gnt0 first, gnt1 next; bank reg3 ends 16'h2222.
REQ-034 hold=1 for 3 cycles with req1=1 -> no gnt, wr_en=0; hold=0 -> gnt1 one cycle later; req1 held 4 more cycles -> gnt1 every other cycle.
REQ-035 Reset asserted at the edge that samples req0=1 -> next cycle gnt0=0, wr_en=0, wr_count=0; req0 still high -> granted one cycle after reset falls.
REQ-036 256 single writes -> wr_count wraps to 0; the 257th write gives wr_count=1.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared register-bank definitions: data width, address width and bank size.
// Latency: n/a (constants only).
// Backpressure: n/a.
package reg_write_arbiter_pkg;

    localparam int REG_DATA_W = 16;
    localparam int REG_ADDR_W = 3;
    localparam int REG_NREG   = 1 << REG_ADDR_W;

endpackage

// File: rtl/addr_decoder.sv
// Address to one-hot write-enable decoder for the register bank.
// Latency: combinational, zero cycles.
// Backpressure: none; onehot is all-zero whenever en is low.
// Ports: en (decode enable), addr (register index), onehot (NREG enables).
module addr_decoder
    import reg_write_arbiter_pkg::*;
#(
    parameter int  ADDR_W = REG_ADDR_W,
    localparam int NREG   = 1 << ADDR_W
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [NREG-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester round-robin arbiter driving one write port of a register bank.
// Latency: one cycle from the sampling edge to gnt/wr_en/wr_data.
// Backpressure: hold freezes grants; requesters keep req high until their gnt pulse.
// Ports: clock/reset (sync, active-high); req/addr/data per requester; hold;
//        gnt0/gnt1 grant pulses; wr_en one-hot bank enables; wr_data; wr_count.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int  DATA_W = REG_DATA_W,
    parameter int  ADDR_W = REG_ADDR_W,
    localparam int NREG   = 1 << ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    input  logic              hold,
    output logic              gnt0,
    output logic              gnt1,
    output logic [NREG-1:0]   wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        wr_count
);

    // last = 1 means requester 1 was granted most recently, so requester 0
    // wins the next contention.
    logic              last;
    logic              elig0;
    logic              elig1;
    logic              pick0;
    logic              pick1;
    logic              any_pick;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-1:0]   dec_onehot;

    // A requester whose grant pulse is currently on the outputs is still
    // holding req (it only sees gnt this cycle), so it must sit out this edge.
    assign elig0    = req0 & ~gnt0 & ~hold;
    assign elig1    = req1 & ~gnt1 & ~hold;
    assign pick0    = elig0 & (~elig1 | last);
    assign pick1    = elig1 & ~pick0;
    assign any_pick = pick0 | pick1;
    assign sel_addr = pick1 ? addr1 : addr0;

    always_comb begin
        sel_data = '0;
        if (pick0) begin
            sel_data = data0;
        end else if (pick1) begin
            sel_data = data1;
        end
    end

    addr_decoder #(
        .ADDR_W (ADDR_W)
    ) u_addr_decoder (
        .en     (any_pick),
        .addr   (sel_addr),
        .onehot (dec_onehot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            wr_en    <= '0;
            wr_data  <= '0;
            wr_count <= 8'd0;
            last     <= 1'b1;
        end else begin
            gnt0    <= pick0;
            gnt1    <= pick1;
            wr_en   <= dec_onehot;
            wr_data <= sel_data;
            if (any_pick) begin
                wr_count <= wr_count + 8'd1;
                last     <= pick1;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a simple register-bank model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: hold and deasserted requests exercised directly.
module tb_reg_write_arbiter;

    logic        clock;
    logic        reset;
    logic        req0;
    logic [2:0]  addr0;
    logic [15:0] data0;
    logic        req1;
    logic [2:0]  addr1;
    logic [15:0] data1;
    logic        hold;
    logic        gnt0;
    logic        gnt1;
    logic [7:0]  wr_en;
    logic [15:0] wr_data;
    logic [7:0]  wr_count;

    logic [15:0] bank [8];

    int passed;
    int total;

    reg_write_arbiter dut (
        .clock    (clock),
        .reset    (reset),
        .req0     (req0),
        .addr0    (addr0),
        .data0    (data0),
        .req1     (req1),
        .addr1    (addr1),
        .data1    (data1),
        .hold     (hold),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .wr_count (wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register bank: each entry captures wr_data when its enable is high.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 8; i++) begin
            if (wr_en[i]) bank[i] <= wr_data;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic g0, input logic g1,
                           input logic [7:0] en, input logic [15:0] dat, input logic [7:0] cnt);
        chk({tag, ".gnt0"},     32'(gnt0),     32'(g0));
        chk({tag, ".gnt1"},     32'(gnt1),     32'(g1));
        chk({tag, ".wr_en"},    32'(wr_en),    32'(en));
        chk({tag, ".wr_data"},  32'(wr_data),  32'(dat));
        chk({tag, ".wr_count"}, 32'(wr_count), 32'(cnt));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        req0   = 1'b0;
        addr0  = 3'd0;
        data0  = 16'h0;
        req1   = 1'b0;
        addr1  = 3'd0;
        data1  = 16'h0;
        hold   = 1'b0;
        for (int i = 0; i < 8; i++) bank[i] = 16'h0;

        // Reset state
        step();
        step();
        chk_out("reset", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd0);
        reset = 1'b0;

        // Single write to register 5
        req0 = 1'b1; addr0 = 3'd5; data0 = 16'hBEEF;
        step();
        chk_out("single", 1'b1, 1'b0, 8'b0010_0000, 16'hBEEF, 8'd1);
        req0 = 1'b0;
        step();
        chk_out("single_idle", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd1);
        step();
        chk("bank5", 32'(bank[5]), 32'h0000BEEF);

        // Continuous contention alternates 0,1,0,1 at full rate
        do_reset();
        req0 = 1'b1; addr0 = 3'd1; data0 = 16'h00A0;
        req1 = 1'b1; addr1 = 3'd2; data1 = 16'h00B1;
        step();
        chk_out("alt1", 1'b1, 1'b0, 8'h02, 16'h00A0, 8'd1);
        step();
        chk_out("alt2", 1'b0, 1'b1, 8'h04, 16'h00B1, 8'd2);
        step();
        chk_out("alt3", 1'b1, 1'b0, 8'h02, 16'h00A0, 8'd3);
        step();
        chk_out("alt4", 1'b0, 1'b1, 8'h04, 16'h00B1, 8'd4);
        req0 = 1'b0; req1 = 1'b0;
        step();
        chk_out("alt_idle", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd4);

        // Same-address collision: loser's data lands last
        do_reset();
        req0 = 1'b1; addr0 = 3'd3; data0 = 16'h1111;
        req1 = 1'b1; addr1 = 3'd3; data1 = 16'h2222;
        step();
        chk_out("coll1", 1'b1, 1'b0, 8'h08, 16'h1111, 8'd1);
        req0 = 1'b0;
        step();
        chk_out("coll2", 1'b0, 1'b1, 8'h08, 16'h2222, 8'd2);
        chk("bank3_first", 32'(bank[3]), 32'h00001111);
        req1 = 1'b0;
        step();
        chk("bank3_final", 32'(bank[3]), 32'h00002222);

        // Hold blocks grants; single requester then gets every other cycle
        do_reset();
        hold = 1'b1; req1 = 1'b1; addr1 = 3'd6; data1 = 16'hC0DE;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("hold", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd0);
        end
        hold = 1'b0;
        step();
        chk_out("hold_rel", 1'b0, 1'b1, 8'h40, 16'hC0DE, 8'd1);
        step();
        chk_out("ss1", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd1);
        step();
        chk_out("ss2", 1'b0, 1'b1, 8'h40, 16'hC0DE, 8'd2);
        step();
        chk_out("ss3", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd2);
        step();
        chk_out("ss4", 1'b0, 1'b1, 8'h40, 16'hC0DE, 8'd3);
        req1 = 1'b0;
        step();

        // Priority survives hold: last grant was 1, so 0 wins after release
        hold = 1'b1; req0 = 1'b1; req1 = 1'b1; addr0 = 3'd0; data0 = 16'h0F0F;
        step();
        chk_out("hold_both", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd3);
        hold = 1'b0;
        step();
        chk_out("hold_prio", 1'b1, 1'b0, 8'h01, 16'h0F0F, 8'd4);
        req0 = 1'b0;
        step();
        chk_out("hold_prio2", 1'b0, 1'b1, 8'h40, 16'hC0DE, 8'd5);
        req1 = 1'b0;
        step();

        // Request withdrawn before grant is ignored
        hold = 1'b1; req0 = 1'b1;
        step();
        req0 = 1'b0; hold = 1'b0;
        step();
        chk_out("withdrawn", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd5);

        // Reset at the sampling edge cancels the grant; served after reset falls
        req0 = 1'b1; addr0 = 3'd4; data0 = 16'h4444; reset = 1'b1;
        step();
        chk_out("rst_edge", 1'b0, 1'b0, 8'h00, 16'h0000, 8'd0);
        reset = 1'b0;
        step();
        chk_out("rst_after", 1'b1, 1'b0, 8'h10, 16'h4444, 8'd1);
        req0 = 1'b0;
        step();

        // Counter wrap over 256 writes, then one more
        do_reset();
        addr0 = 3'd7; data0 = 16'h7777;
        for (int i = 1; i <= 257; i++) begin
            req0 = 1'b1;
            step();
            chk("wrap.gnt0", 32'(gnt0), 32'd1);
            req0 = 1'b0;
            if (i == 255) chk("wrap.cnt255", 32'(wr_count), 32'd255);
            if (i == 256) chk("wrap.cnt256", 32'(wr_count), 32'd0);
            if (i == 257) chk("wrap.cnt257", 32'(wr_count), 32'd1);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
